// File: rtl/am_magnitude_scheduler.sv
// am_magnitude_scheduler: round-robin time-shared floor(sqrt(I^2+Q^2)) engine for NUM_CH I/Q channels
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid / in_ready     per-channel handshake; in_ready is one-hot or zero, only in IDLE
//   inphase / quadrature    packed signed I/Q, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   out_valid               one-cycle result pulse
//   out_channel / out_mag   tag and magnitude of the last result, held until the next one
//   busy                    high whenever the engine is not IDLE
module am_magnitude_scheduler #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_CH = 4,
  parameter int CH_W = $clog2(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH-1:0]              in_valid,
  output logic [NUM_CH-1:0]              in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   inphase,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   quadrature,
  output logic                           out_valid,
  output logic [CH_W-1:0]                out_channel,
  output logic [DATA_WIDTH-1:0]          out_mag,
  output logic                           busy
);
  localparam int PW = 2*DATA_WIDTH;
  localparam int RW = 2*DATA_WIDTH+2;
  localparam int NR = DATA_WIDTH+1;
  localparam int MW = DATA_WIDTH+4;
  localparam int CW = $clog2(DATA_WIDTH+2);
  typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;
  state_t r_state, w_next;
  logic [CH_W-1:0] r_ptr, r_tag, r_ch, w_gnt, w_ptr_nx;
  logic signed [DATA_WIDTH-1:0] r_i, r_q;
  logic [RW-1:0] r_rad;
  logic [MW-1:0] r_rem, w_trial, w_div, w_rem_nx;
  logic [NR-1:0] r_root, w_root_nx;
  logic [CW-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_mag;
  logic signed [PW-1:0] w_ii, w_qq;
  logic [PW-1:0] w_sum;
  logic w_found, w_hs;
  // lowest offset from the pointer wins, giving round-robin with wrap
  always_comb begin
    w_found = 1'b0;
    w_gnt = '0;
    for (int k = NUM_CH-1; k >= 0; k--) begin
      if (in_valid[CH_W'((int'(r_ptr) + k) % NUM_CH)]) begin
        w_found = 1'b1;
        w_gnt = CH_W'((int'(r_ptr) + k) % NUM_CH);
      end
    end
  end
  assign w_hs = (r_state == IDLE) && w_found;
  assign in_ready = w_hs ? (NUM_CH'(1) << w_gnt) : '0;
  assign w_ptr_nx = (w_gnt == CH_W'(NUM_CH-1)) ? '0 : w_gnt + 1'b1;
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_found ? SQUARE : IDLE;
      SQUARE:  w_next = ROOT;
      ROOT:    w_next = (r_cnt == CW'(1)) ? DONE : ROOT;
      default: w_next = IDLE;
    endcase
  end
  assign busy = r_state != IDLE;
  assign out_valid = r_state == DONE;
  assign out_channel = r_ch;
  assign out_mag = r_mag;
  assign w_ii = PW'(r_i) * PW'(r_i);
  assign w_qq = PW'(r_q) * PW'(r_q);
  assign w_sum = w_ii + w_qq;
  // non-restoring step; the remainder wraps harmlessly because every true result fits MW signed bits
  assign w_trial = (r_rem << 2) | {{(MW-2){1'b0}}, r_rad[RW-1 -: 2]};
  assign w_div = {1'b0, r_root, r_rem[MW-1], 1'b1};
  assign w_rem_nx = r_rem[MW-1] ? w_trial + w_div : w_trial - w_div;
  assign w_root_nx = {r_root[NR-2:0], ~w_rem_nx[MW-1]};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_tag <= '0;
      r_ch <= '0;
      r_i <= '0;
      r_q <= '0;
      r_rad <= '0;
      r_rem <= '0;
      r_root <= '0;
      r_cnt <= '0;
      r_mag <= '0;
    end else begin
      if (w_hs) begin
        r_i <= inphase[w_gnt*DATA_WIDTH +: DATA_WIDTH];
        r_q <= quadrature[w_gnt*DATA_WIDTH +: DATA_WIDTH];
        r_tag <= w_gnt;
        r_ptr <= w_ptr_nx;
      end
      if (r_state == SQUARE) begin
        r_rad <= {2'b00, w_sum};
        r_rem <= '0;
        r_root <= '0;
        r_cnt <= CW'(DATA_WIDTH+1);
      end
      if (r_state == ROOT) begin
        r_rad <= r_rad << 2;
        r_rem <= w_rem_nx;
        r_root <= w_root_nx;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_mag <= w_root_nx[DATA_WIDTH-1:0];
          r_ch <= r_tag;
        end
      end
    end
  end
endmodule

// File: tb/tb_am_magnitude_scheduler.sv
// tb_am_magnitude_scheduler: directed self-checking bench for am_magnitude_scheduler
module tb_am_magnitude_scheduler;
  localparam int DW = 12;
  localparam int NC = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NC-1:0] in_valid, in_ready;
  logic [NC*DW-1:0] inphase, quadrature;
  logic out_valid, busy;
  logic [1:0] out_channel;
  logic [DW-1:0] out_mag;
  int n_run = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  am_magnitude_scheduler #(.DATA_WIDTH(DW), .NUM_CH(NC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inphase(inphase), .quadrature(quadrature), .out_valid(out_valid),
    .out_channel(out_channel), .out_mag(out_mag), .busy(busy)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic set_iq(input int ch, input int i, input int q);
    inphase[ch*DW +: DW] = DW'(i);
    quadrature[ch*DW +: DW] = DW'(q);
  endtask
  task automatic do_reset;
    @(posedge clk);
    #1 rst_n = 1'b0;
    in_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
  endtask
  task automatic run_one(input string tag, input int ch, input int i, input int q, input int exp);
    int n;
    @(posedge clk);
    #1 set_iq(ch, i, q);
    in_valid = NC'(1 << ch);
    @(negedge clk);
    check({tag, "_rdy"}, in_ready, 1 << ch);
    @(posedge clk);
    #1 in_valid = '0;
    wait_out(n);
    check({tag, "_lat"}, n, 15);
    check({tag, "_mag"}, out_mag, exp);
    check({tag, "_ch"}, out_channel, ch);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n, gk, ok, cnt;
    int rr_mag[4];
    rr_mag = '{5, 13, 9, 2895};
    inphase = '0;
    quadrature = '0;
    in_valid = '0;
    do_reset;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ov", out_valid, 0);
    check("rst_ready", in_ready, 0);
    // ch0 3,4 with exact cycle timing; ch1 waits pending while busy
    @(posedge clk);
    #1 set_iq(0, 3, 4);
    in_valid = 4'b0001;
    @(negedge clk);
    check("t1_rdy", in_ready, 1);
    check("t1_busy0", busy, 0);
    @(posedge clk);
    #1 set_iq(1, 6, 8);
    in_valid = 4'b0010;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      check("t1_busy", busy, int'(c <= 15));
      check("t1_ov", out_valid, int'(c == 15));
      check("t1_ready", in_ready, (c == 16) ? 2 : 0);
      if (c == 15) begin
        check("t1_mag", out_mag, 5);
        check("t1_ch", out_channel, 0);
      end
    end
    @(posedge clk);
    #1 in_valid = '0;
    wait_out(n);
    check("t1b_lat", n, 15);
    check("t1b_mag", out_mag, 10);
    check("t1b_ch", out_channel, 1);
    run_one("neg_max", 1, -2048, -2048, 2896);
    run_one("mixed_max", 3, 2047, -2048, 2895);
    run_one("zero", 2, 0, 0, 0);
    run_one("floor", 0, 7, 7, 9);
    run_one("axis", 2, -2048, 0, 2048);
    // all channels requesting continuously
    do_reset;
    set_iq(0, 3, 4);
    set_iq(1, -5, 12);
    set_iq(2, 7, 7);
    set_iq(3, 2047, -2048);
    @(posedge clk);
    #1 in_valid = 4'hF;
    gk = 0;
    ok = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (in_ready != 0) begin
        check("rr_gnt", in_ready, 1 << (gk % 4));
        check("rr_gcyc", cyc, 16*gk);
        gk++;
      end
      if (out_valid) begin
        check("rr_ch", out_channel, ok % 4);
        check("rr_mag", out_mag, rr_mag[ok % 4]);
        check("rr_ocyc", cyc, 16*ok + 15);
        ok++;
      end
    end
    check("rr_ngnt", gk, 5);
    check("rr_nout", ok, 5);
    @(posedge clk);
    #1 in_valid = '0;
    // pointer advance past a lone requester
    do_reset;
    run_one("p_ch2", 2, 6, 8, 10);
    @(posedge clk);
    #1 set_iq(0, 3, 4);
    set_iq(3, 0, 9);
    in_valid = 4'b1001;
    @(negedge clk);
    check("p_rdy3", in_ready, 8);
    @(posedge clk);
    #1 in_valid = 4'b0001;
    wait_out(n);
    check("p3_lat", n, 15);
    check("p3_ch", out_channel, 3);
    check("p3_mag", out_mag, 9);
    @(negedge clk);
    check("p_rdy0", in_ready, 1);
    @(posedge clk);
    #1 in_valid = '0;
    wait_out(n);
    check("p0_lat", n, 15);
    check("p0_ch", out_channel, 0);
    check("p0_mag", out_mag, 5);
    // reset in the middle of ROOT aborts the sample and clears the pointer
    @(posedge clk);
    #1 set_iq(0, 6, 8);
    in_valid = 4'b0001;
    @(posedge clk);
    #1 in_valid = '0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ab_busy", busy, 0);
    check("ab_mag", out_mag, 0);
    check("ab_ch", out_channel, 0);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("ab_noout", cnt, 0);
    @(posedge clk);
    #1 set_iq(1, -5, 12);
    in_valid = 4'b0011;
    @(negedge clk);
    check("ab_rdy0", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 4'b0010;
    wait_out(n);
    check("ab0_lat", n, 15);
    check("ab0_ch", out_channel, 0);
    check("ab0_mag", out_mag, 10);
    @(negedge clk);
    check("ab_rdy1", in_ready, 2);
    @(posedge clk);
    #1 in_valid = '0;
    wait_out(n);
    check("ab1_lat", n, 15);
    check("ab1_ch", out_channel, 1);
    check("ab1_mag", out_mag, 13);
    // inputs changed after the handshake must not reach the result
    @(posedge clk);
    #1 set_iq(2, 5, 12);
    in_valid = 4'b0100;
    @(negedge clk);
    check("hold_rdy", in_ready, 4);
    @(posedge clk);
    #1 in_valid = '0;
    set_iq(2, 100, 100);
    wait_out(n);
    check("hold_lat", n, 15);
    check("hold_mag", out_mag, 13);
    check("hold_ch", out_channel, 2);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
